// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: state codes,
// branch codes and the bundle of per-cycle control strobes.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    // Decoded branch codes; any code with the BR_COND bit set is conditional.
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam int         BR_COND = 2;

    // Every strobe the sequencer can raise in one cycle.
    typedef struct packed {
        logic imem_req;
        logic ir_we;
        logic dmem_req;
        logic dmem_we;
        logic rf_we;
        logic pc_we;
        logic pc_sel_branch;
    } strobe_t;

    // Unconditional jumps finish through WB so the link register is written.
    function automatic logic is_jump(input logic [2:0] br);
        return (br == BR_JAL) || (br == BR_JALR);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive not-ready cycles while the sequencer waits on a memory.
// timeout flags that the current cycle is the last one tolerated, so a
// not-ready response in this cycle sends the sequencer to FAULT.
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Wait counter: cleared on reset or state change, saturates at the last tolerated cycle
    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (count_en && !timeout)
            cnt <= cnt + 1'b1;
    end

    assign timeout = (cnt == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with Mealy
// strobes so IR, PC, register file and data memory each fire once per
// instruction. A shared wait timer faults on a stalled memory.
module multicycle_seq
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             instr_nop,
    input  logic             regwr,
    input  logic             memwr,
    input  logic             MemtoReg,
    input  logic [2:0]       branch,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t  cur, nxt;
    state_t  after_instr;
    strobe_t sb;
    logic    timeout;
    logic    wait_clear;
    logic    wait_count;

    // Where an instruction goes once it retires: keep running or park.
    assign after_instr = run ? S_FETCH : S_IDLE;

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    // Next-state logic; ready always wins over timeout
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (imem_ready)
                    nxt = S_DECODE;
                else if (timeout)
                    nxt = S_FAULT;
            end
            S_DECODE: nxt = instr_nop ? after_instr : S_EXEC;
            S_EXEC: begin
                if (branch[BR_COND])
                    nxt = after_instr;
                else if (is_jump(branch))
                    nxt = S_WB;
                else if (MemtoReg || memwr)
                    nxt = S_MEM;
                else
                    nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)
                    nxt = memwr ? after_instr : S_WB;
                else if (timeout)
                    nxt = S_FAULT;
            end
            S_WB:     nxt = after_instr;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_IDLE;
        endcase
    end

    // Strobe decode; reset overrides everything so an abandoned instruction emits nothing
    always_comb begin
        sb = '0;
        case (cur)
            S_FETCH: begin
                sb.imem_req = 1'b1;
                sb.ir_we    = imem_ready;
            end
            S_DECODE: begin
                sb.pc_we = instr_nop;
            end
            S_EXEC: begin
                sb.pc_we         = branch[BR_COND];
                sb.pc_sel_branch = branch[BR_COND];
            end
            S_MEM: begin
                sb.dmem_req = 1'b1;
                sb.dmem_we  = memwr;
                sb.pc_we    = dmem_ready && memwr;
            end
            S_WB: begin
                sb.rf_we         = regwr;
                sb.pc_we         = 1'b1;
                sb.pc_sel_branch = (branch != BR_NONE);
            end
            default: sb = '0;
        endcase
        if (reset)
            sb = '0;
    end

    // Wait timer restarts whenever the state changes, so entry to FETCH/MEM starts at zero.
    assign wait_clear = (nxt != cur);
    assign wait_count = ((cur == S_FETCH) && !imem_ready) ||
                        ((cur == S_MEM)   && !dmem_ready);

    seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .clock    (clock),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_count),
        .timeout  (timeout)
    );

    // Retired-instruction counter: one tick per PC update
    always_ff @(posedge clock) begin
        if (reset)
            instr_cnt <= '0;
        else if (sb.pc_we)
            instr_cnt <= instr_cnt + 1'b1;
    end

    assign imem_req      = sb.imem_req;
    assign ir_we         = sb.ir_we;
    assign dmem_req      = sb.dmem_req;
    assign dmem_we       = sb.dmem_we;
    assign rf_we         = sb.rf_we;
    assign pc_we         = sb.pc_we;
    assign pc_sel_branch = sb.pc_sel_branch;
    assign state         = cur;
    assign fault         = (cur == S_FAULT);
    assign busy          = (cur != S_IDLE) && (cur != S_FAULT);

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: each instruction is expanded into a per-cycle
// schedule of expected state/strobes from the instruction's type and its
// memory latencies, then replayed against the design cycle by cycle.
module tb_multicycle_seq;

    localparam int TO    = 16;
    localparam int CNT_W = 32;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_COND = 3,
                   K_JAL = 4, K_JALR = 5, K_NOP = 6;

    logic clock = 1'b0;
    logic reset, run, instr_nop, regwr, memwr, MemtoReg;
    logic [2:0] branch;
    logic imem_ready, dmem_ready;
    logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel_branch;
    logic busy, fault;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_cnt;

    multicycle_seq #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .run(run), .instr_nop(instr_nop),
        .regwr(regwr), .memwr(memwr), .MemtoReg(MemtoReg), .branch(branch),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel_branch(pc_sel_branch), .busy(busy), .fault(fault),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clock = ~clock;

    // One expected cycle. sb = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel_branch}
    typedef struct {
        logic       rst, run, nop, rw, mw, m2r;
        logic [2:0] br;
        logic       ir, dr;
        logic [2:0] st;
        logic [6:0] sb;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    // Decoded controls of the instruction being scheduled
    logic       d_nop, d_rw, d_mw, d_m2r;
    logic [2:0] d_br;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [2:0] st, input logic ir, input logic dr,
                                input logic [6:0] sb);
        rec_t r;
        r.rst = 1'b0; r.run = 1'($urandom);
        r.nop = d_nop; r.rw = d_rw; r.mw = d_mw; r.m2r = d_m2r; r.br = d_br;
        r.ir = ir; r.dr = dr; r.st = st; r.sb = sb;
        return r;
    endfunction

    task automatic push_idle(input logic run_v);
        rec_t r;
        r = mk(3'd0, 1'($urandom), 1'($urandom), 7'b0);
        r.run = run_v;
        q.push_back(r);
    endtask

    task automatic push_reset(input logic [2:0] cur_st);
        rec_t r;
        r = mk(cur_st, 1'($urandom), 1'($urandom), 7'b0);
        r.rst = 1'b1;
        q.push_back(r);
    endtask

    task automatic finish_instr(input logic run_end);
        rec_t r;
        r = q.pop_back();
        r.run = run_end;
        q.push_back(r);
    endtask

    task automatic push_fault(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(3'd7, 1'($urandom), 1'($urandom), 7'b0));
    endtask

    // Expand one instruction into its cycle schedule. A wait >= TO ends in FAULT.
    task automatic build(input int kind, input logic rw, input int fw, input int mw,
                         input logic run_end);
        d_nop = 1'b0; d_rw = rw; d_mw = 1'b0; d_m2r = 1'b0; d_br = 3'b000;
        case (kind)
            K_LOAD:  d_m2r = 1'b1;
            K_STORE: begin d_mw = 1'b1; d_rw = 1'b0; end
            K_COND:  d_br = {1'b1, 2'($urandom)};
            K_JAL:   d_br = 3'b001;
            K_JALR:  d_br = 3'b010;
            K_NOP:   begin
                d_nop = 1'b1; d_mw = 1'($urandom); d_m2r = 1'($urandom); d_br = 3'($urandom);
            end
            default: ;
        endcase
        for (int i = 0; i < fw && i < TO; i++) q.push_back(mk(3'd1, 1'b0, 1'($urandom), 7'b1000000));
        if (fw >= TO) begin push_fault(20); return; end
        q.push_back(mk(3'd1, 1'b1, 1'($urandom), 7'b1100000));
        if (kind == K_NOP) begin
            q.push_back(mk(3'd2, 1'($urandom), 1'($urandom), 7'b0000010));
            finish_instr(run_end); return;
        end
        q.push_back(mk(3'd2, 1'($urandom), 1'($urandom), 7'b0));
        if (kind == K_COND) begin
            q.push_back(mk(3'd3, 1'($urandom), 1'($urandom), 7'b0000011));
            finish_instr(run_end); return;
        end
        q.push_back(mk(3'd3, 1'($urandom), 1'($urandom), 7'b0));
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int i = 0; i < mw && i < TO; i++)
                q.push_back(mk(3'd4, 1'($urandom), 1'b0, {2'b00, 1'b1, d_mw, 3'b000}));
            if (mw >= TO) begin push_fault(5); return; end
            q.push_back(mk(3'd4, 1'($urandom), 1'b1, {2'b00, 1'b1, d_mw, 1'b0, d_mw, 1'b0}));
            if (kind == K_STORE) begin finish_instr(run_end); return; end
        end
        q.push_back(mk(3'd5, 1'($urandom), 1'($urandom),
                       {4'b0000, d_rw, 1'b1, (d_br != 3'b000)}));
        finish_instr(run_end);
    endtask

    task automatic step(input rec_t r);
        logic exp_busy, exp_fault;
        @(negedge clock);
        reset = r.rst; run = r.run; instr_nop = r.nop; regwr = r.rw; memwr = r.mw;
        MemtoReg = r.m2r; branch = r.br; imem_ready = r.ir; dmem_ready = r.dr;
        #1;
        exp_busy  = (r.st != 3'd0) && (r.st != 3'd7);
        exp_fault = (r.st == 3'd7);
        chk("state", 64'(state), 64'(r.st));
        chk("strobes", 64'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel_branch}),
            64'(r.sb));
        chk("busy_fault", 64'({busy, fault}), 64'({exp_busy, exp_fault}));
        chk("instr_cnt", 64'(instr_cnt), 64'(cnt_model));
        if (r.rst) cnt_model = '0;
        else if (r.sb[1]) cnt_model = cnt_model + 1'b1;
        cyc++;
    endtask

    task automatic play();
        while (q.size() > 0) step(q.pop_front());
    endtask

    initial begin
        int   kind, fw, mw;
        logic re, prev_re;
        reset = 1'b1; run = 1'b0; instr_nop = 1'b0; regwr = 1'b0; memwr = 1'b0;
        MemtoReg = 1'b0; branch = 3'b000; imem_ready = 1'b0; dmem_ready = 1'b0;
        d_nop = 1'b0; d_rw = 1'b0; d_mw = 1'b0; d_m2r = 1'b0; d_br = 3'b000;
        repeat (2) @(posedge clock);

        // Reset state, strobes held low while reset is high
        push_reset(3'd0);
        push_idle(1'b0);
        play();

        // ALU op: FETCH, DECODE, EXEC, WB then park in IDLE with one retired
        push_idle(1'b1);
        build(K_ALU, 1'b1, 0, 0, 1'b0);
        push_idle(1'b0);
        play();

        // Directed load/store/branch/jal/nop chain back-to-back
        push_idle(1'b1);
        build(K_LOAD,  1'b1, 0, 3, 1'b1);
        build(K_STORE, 1'b0, 0, 2, 1'b1);
        build(K_COND,  1'b0, 0, 0, 1'b1);
        build(K_JAL,   1'b1, 0, 0, 1'b1);
        build(K_NOP,   1'b0, 0, 0, 1'b1);
        build(K_JALR,  1'b1, 1, 0, 1'b1);
        // Ready on the last tolerated wait cycle is accepted in both FETCH and MEM
        build(K_ALU,   1'b1, TO - 1, 0, 1'b1);
        build(K_LOAD,  1'b1, 0, TO - 1, 1'b0);
        push_idle(1'b0);
        play();

        // Randomized instruction stream with random latencies and run toggling
        prev_re = 1'b0;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 6);
            fw = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 4);
            mw = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 4);
            re = (n == 59) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            if (!prev_re) begin
                if ($urandom_range(0, 1) == 1) push_idle(1'b0);
                push_idle(1'b1);
            end
            build(kind, 1'($urandom), fw, mw, re);
            prev_re = re;
            play();
        end
        push_idle(1'b0);
        play();

        // FETCH timeout: 16 not-ready cycles then sticky FAULT, cleared only by reset
        push_idle(1'b1);
        build(K_ALU, 1'b1, TO, 0, 1'b1);
        push_reset(3'd7);
        push_idle(1'b0);
        play();

        // MEM timeout on a load
        push_idle(1'b1);
        build(K_LOAD, 1'b1, 0, TO, 1'b1);
        push_reset(3'd7);
        push_idle(1'b0);
        play();

        // Retire one, then reset mid-MEM on a store: no strobe, counter back to 0
        push_idle(1'b1);
        build(K_ALU, 1'b1, 0, 0, 1'b1);
        play();
        build(K_STORE, 1'b0, 0, 10, 1'b1);
        for (int i = 0; i < 7; i++) step(q.pop_front());
        q.delete();
        push_reset(3'd4);
        for (int i = 0; i < 3; i++) push_idle(1'b0);
        play();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
